// File: rtl/apu_pkg.sv
// apu_pkg: shared types, ROM entry layout and duty decode for the APU sound-effect sequencer.
// Optional feature macro APU_SFX_PREEMPT_EN: when defined, a pending request with a lower
// index than the effect being played (in LOAD or PLAY) aborts that effect and restarts
// the sequencer on the new id; the aborted effect gets no sfx_done and is not re-queued.
// When undefined, higher-priority requests simply wait in pending until the current effect ends.
package apu_pkg;

    localparam int DEF_NUM_SFX   = 4;
    localparam int DEF_NOTES_MAX = 4;
    localparam int DEF_PERIOD_W  = 16;
    localparam int DEF_LEN_W     = 4;

    localparam logic [1:0] DUTY_50 = 2'b00;
    localparam logic [1:0] DUTY_25 = 2'b01;
    localparam logic [1:0] DUTY_12 = 2'b10;
    localparam logic [1:0] DUTY_6  = 2'b11;

    typedef struct packed {
        logic [DEF_PERIOD_W-1:0] period;
        logic [1:0]              duty;
        logic [DEF_LEN_W-1:0]    len;
    } rom_entry_t;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_DONE} state_t;

    function automatic logic [7:0] duty_decode(input logic [1:0] code);
        return 8'd128 >> code;
    endfunction

endpackage

// File: rtl/apu_sfx_sequencer_if.sv
// apu_sfx_sequencer_if: request/tick inputs and tone-generator outputs of the sfx sequencer.
interface apu_sfx_sequencer_if import apu_pkg::*; #(
    parameter int NUM_SFX  = DEF_NUM_SFX,
    parameter int PERIOD_W = DEF_PERIOD_W,
    parameter int ID_W     = $clog2(NUM_SFX)
);
    logic                tick;
    logic [NUM_SFX-1:0]  sfx_req;
    logic                tone_en;
    logic [PERIOD_W-1:0] tone_period;
    logic [7:0]          tone_duty;
    logic                busy;
    logic [ID_W-1:0]     active_id;
    logic                sfx_done;

    modport master (
        output tick, sfx_req,
        input  tone_en, tone_period, tone_duty, busy, active_id, sfx_done
    );

    modport slave (
        input  tick, sfx_req,
        output tone_en, tone_period, tone_duty, busy, active_id, sfx_done
    );
endinterface

// File: rtl/apu_sfx_rom.sv
// apu_sfx_rom: fixed sound-effect note table, combinational (id, note_idx) -> entry lookup.
module apu_sfx_rom import apu_pkg::*; #(
    parameter int PERIOD_W = DEF_PERIOD_W,
    parameter int LEN_W    = DEF_LEN_W,
    parameter int ID_W     = 2,
    parameter int IDX_W    = 2
) (
    input  logic [ID_W-1:0]     i_id,
    input  logic [IDX_W-1:0]    i_note_idx,
    output logic [PERIOD_W-1:0] o_period,
    output logic [1:0]          o_duty,
    output logic [LEN_W-1:0]    o_len
);
    rom_entry_t w_entry;
    int         w_key;

    // Effect table keyed as id*16 + note; any unlisted slot reads as end-of-effect (len 0).
    always_comb begin
        w_key   = int'(i_id) * 16 + int'(i_note_idx);
        w_entry = '0;
        case (w_key)
            0:       w_entry = rom_entry_t'{16'd12500, DUTY_50, 4'd2};
            1:       w_entry = rom_entry_t'{16'd6250,  DUTY_25, 4'd1};
            16:      w_entry = rom_entry_t'{16'd9000,  DUTY_12, 4'd1};
            48:      w_entry = rom_entry_t'{16'd1000,  DUTY_6,  4'd1};
            49:      w_entry = rom_entry_t'{16'd2000,  DUTY_12, 4'd1};
            50:      w_entry = rom_entry_t'{16'd3000,  DUTY_25, 4'd1};
            51:      w_entry = rom_entry_t'{16'd4000,  DUTY_50, 4'd1};
            default: w_entry = '0;
        endcase
    end

    assign o_period = PERIOD_W'(w_entry.period);
    assign o_duty   = w_entry.duty;
    assign o_len    = LEN_W'(w_entry.len);
endmodule

// File: rtl/apu_sfx_sequencer.sv
// apu_sfx_sequencer: fixed-priority sound-effect arbiter and note sequencer driving the PWM tone generator.
// Optional preemption is enabled by defining APU_SFX_PREEMPT_EN.
module apu_sfx_sequencer import apu_pkg::*; #(
    parameter int NUM_SFX   = DEF_NUM_SFX,
    parameter int NOTES_MAX = DEF_NOTES_MAX,
    parameter int PERIOD_W  = DEF_PERIOD_W,
    parameter int LEN_W     = DEF_LEN_W
) (
    input  logic               clk,
    input  logic               rst,
    apu_sfx_sequencer_if.slave sfx
);
    localparam int ID_W  = $clog2(NUM_SFX);
    localparam int IDX_W = $clog2(NOTES_MAX);

    state_t              r_state;
    state_t              w_next;
    logic [NUM_SFX-1:0]  r_pending;
    logic [NUM_SFX-1:0]  w_clr;
    logic [ID_W-1:0]     r_active_id;
    logic [ID_W-1:0]     w_grant;
    logic [IDX_W-1:0]    r_note_idx;
    logic [LEN_W-1:0]    r_tick_cnt;
    logic [LEN_W-1:0]    w_len;
    logic [PERIOD_W-1:0] r_tone_period;
    logic [PERIOD_W-1:0] w_period;
    logic [1:0]          w_duty_code;
    logic [7:0]          r_tone_duty;
    logic                r_tone_en;
    logic                w_take;
    logic                w_note_end;
    logic                w_last;
    logic                w_preempt;

    apu_sfx_rom #(
        .PERIOD_W (PERIOD_W),
        .LEN_W    (LEN_W),
        .ID_W     (ID_W),
        .IDX_W    (IDX_W)
    ) u_rom (
        .i_id       (r_active_id),
        .i_note_idx (r_note_idx),
        .o_period   (w_period),
        .o_duty     (w_duty_code),
        .o_len      (w_len)
    );

    // Fixed-priority arbiter: the lowest set pending index wins.
    always_comb begin
        w_grant = '0;
        for (int i = NUM_SFX - 1; i >= 0; i--)
            if (r_pending[i]) w_grant = ID_W'(i);
    end

`ifdef APU_SFX_PREEMPT_EN
    assign w_preempt = (r_state == S_LOAD || r_state == S_PLAY) && |r_pending && w_grant < r_active_id;
`else
    assign w_preempt = 1'b0;
`endif

    assign w_note_end = r_state == S_PLAY && sfx.tick && r_tick_cnt == w_len - 1'b1;
    assign w_last     = r_note_idx == IDX_W'(NOTES_MAX - 1);
    assign w_clr      = w_take ? NUM_SFX'(1) << w_grant : '0;

    // Next-state decode; a preemption overrides whatever LOAD/PLAY would otherwise do.
    always_comb begin
        w_next = r_state;
        w_take = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_next = |r_pending ? S_LOAD : S_IDLE;
                w_take = |r_pending;
            end
            S_LOAD:  w_next = w_len == '0 ? S_DONE : S_PLAY;
            S_PLAY:  w_next = !w_note_end ? S_PLAY : w_last ? S_DONE : S_LOAD;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (w_preempt) begin
            w_next = S_LOAD;
            w_take = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Pending set/clear (new request wins over grant clear), note/tick counters and tone outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending     <= '0;
            r_active_id   <= '0;
            r_note_idx    <= '0;
            r_tick_cnt    <= '0;
            r_tone_period <= '0;
            r_tone_duty   <= '0;
            r_tone_en     <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | sfx.sfx_req;
            if (w_take) begin
                r_active_id <= w_grant;
                r_note_idx  <= '0;
            end else if (w_note_end && !w_last) begin
                r_note_idx <= r_note_idx + 1'b1;
            end
            r_tick_cnt <= (r_state != S_PLAY || w_take || w_note_end) ? '0 : r_tick_cnt + LEN_W'(sfx.tick);
            if (r_state == S_LOAD && !w_preempt && w_len != '0) begin
                r_tone_period <= w_period;
                r_tone_duty   <= duty_decode(w_duty_code);
                r_tone_en     <= 1'b1;
            end else if (w_next == S_DONE) begin
                r_tone_en <= 1'b0;
            end
        end
    end

    assign sfx.tone_en     = r_tone_en;
    assign sfx.tone_period = r_tone_period;
    assign sfx.tone_duty   = r_tone_duty;
    assign sfx.busy        = r_state != S_IDLE;
    assign sfx.active_id   = r_active_id;
    assign sfx.sfx_done    = r_state == S_DONE;
endmodule

// File: tb/tb_apu_sfx_sequencer.sv
// tb_apu_sfx_sequencer: directed stimulus with a note/done event scoreboard for apu_sfx_sequencer.
module tb_apu_sfx_sequencer;
    typedef struct {
        int kind;
        int a;
        int b;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   done_mark;
    ev_t  exp_q[$];
    logic        p_en = 1'b0;
    logic [15:0] p_per = '0;
    logic [7:0]  p_duty = '0;

`ifdef APU_SFX_PREEMPT_EN
    localparam int EXP_DONE = 9;
`else
    localparam int EXP_DONE = 10;
`endif

    apu_sfx_sequencer_if bus ();

    apu_sfx_sequencer dut (
        .clk (clk),
        .rst (rst),
        .sfx (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_note(input int period, input int duty);
        exp_q.push_back('{0, period, duty});
    endtask

    task automatic push_done(input int id);
        exp_q.push_back('{1, id, 0});
    endtask

    task automatic push_sfx0();
        push_note(12500, 128);
        push_note(6250, 64);
        push_done(0);
    endtask

    task automatic sb_pop(input int kind, input int a, input int b);
        ev_t e;
        checks++;
        assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL sb_unexpected: got event kind %0d value %0d expected no event", kind, a);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sb_kind", kind, e.kind);
            chk("sb_value", a, e.a);
            if (kind == 0) chk("sb_duty", b, e.b);
        end
    endtask

    // Observe tone changes and done pulses away from the active edge and score them.
    always @(negedge clk) begin
        if (bus.tone_en && (!p_en || bus.tone_period != p_per || bus.tone_duty != p_duty))
            sb_pop(0, int'(bus.tone_period), int'(bus.tone_duty));
        if (bus.sfx_done) begin
            done_cnt++;
            sb_pop(1, int'(bus.active_id), 0);
        end
        p_en   = bus.tone_en;
        p_per  = bus.tone_period;
        p_duty = bus.tone_duty;
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick_pulse();
        step(99);
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
    endtask

    task automatic req(input logic [3:0] v);
        bus.sfx_req = v;
        step();
        bus.sfx_req = '0;
    endtask

    // sfx0 from PLAY of note 0 through DONE; leaves the bench one cycle after DONE.
    task automatic play_sfx0_rest(input string tag);
        tick_pulse();
        tick_pulse();
        step();
        chk({tag, "_n1_period"}, bus.tone_period, 6250);
        tick_pulse();
        step();
        chk({tag, "_done"}, bus.sfx_done, 1);
        chk({tag, "_done_id"}, bus.active_id, 0);
        step();
    endtask

    initial begin
        bus.tick    = 1'b0;
        bus.sfx_req = '0;
        step(3);
        chk("rst_tone_en", bus.tone_en, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.sfx_done, 0);
        chk("rst_id", bus.active_id, 0);
        chk("rst_period", bus.tone_period, 0);
        chk("rst_duty", bus.tone_duty, 0);
        rst = 1'b0;
        step(3);

        // Single effect from idle: latency, note change after 2 ticks, done after 1 more.
        push_sfx0();
        done_mark = done_cnt;
        req(4'b0001);
        chk("t2_k_tone_en", bus.tone_en, 0);
        step();
        chk("t2_load_busy", bus.busy, 1);
        chk("t2_load_tone_en", bus.tone_en, 0);
        step();
        chk("t2_play_tone_en", bus.tone_en, 1);
        chk("t2_play_period", bus.tone_period, 12500);
        chk("t2_play_duty", bus.tone_duty, 128);
        tick_pulse();
        chk("t2_one_tick_period", bus.tone_period, 12500);
        tick_pulse();
        chk("t2_gap_tone_en", bus.tone_en, 1);
        step();
        chk("t2_n1_period", bus.tone_period, 6250);
        chk("t2_n1_duty", bus.tone_duty, 64);
        tick_pulse();
        step();
        chk("t2_done", bus.sfx_done, 1);
        chk("t2_done_tone_en", bus.tone_en, 0);
        step();
        chk("t2_done_once", bus.sfx_done, 0);
        chk("t2_idle_busy", bus.busy, 0);
        chk("t2_done_count", done_cnt - done_mark, 1);
        step(10);

        // Ticks landing in LOAD are ignored, both before note 0 and between notes.
        push_sfx0();
        bus.sfx_req = 4'b0001;
        step();
        bus.sfx_req = '0;
        step();
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        chk("t6_play_tone_en", bus.tone_en, 1);
        tick_pulse();
        chk("t6_note0_hold", bus.tone_period, 12500);
        tick_pulse();
        chk("t6_no_glitch", bus.tone_en, 1);
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        chk("t6_n1_period", bus.tone_period, 6250);
        step();
        chk("t6_n1_not_done", bus.sfx_done, 0);
        chk("t6_n1_busy", bus.busy, 1);
        tick_pulse();
        step();
        chk("t6_done", bus.sfx_done, 1);
        step(10);

        // Simultaneous requests: sfx0 completes, then sfx1 is loaded.
        push_sfx0();
        push_note(9000, 32);
        push_done(1);
        req(4'b0011);
        step(2);
        play_sfx0_rest("t3");
        chk("t3_idle_busy", bus.busy, 0);
        step();
        chk("t3_load_busy", bus.busy, 1);
        chk("t3_load_id", bus.active_id, 1);
        chk("t3_load_tone_en", bus.tone_en, 0);
        step();
        chk("t3_sfx1_period", bus.tone_period, 9000);
        chk("t3_sfx1_duty", bus.tone_duty, 32);
        tick_pulse();
        step();
        chk("t3_sfx1_done", bus.sfx_done, 1);
        chk("t3_sfx1_done_id", bus.active_id, 1);
        step(10);

        // Higher-priority request arriving while sfx1 plays.
        push_note(9000, 32);
`ifndef APU_SFX_PREEMPT_EN
        push_done(1);
`endif
        push_sfx0();
        req(4'b0010);
        step(2);
        step(20);
        req(4'b0001);
        step();
`ifdef APU_SFX_PREEMPT_EN
        chk("t4_preempt_id", bus.active_id, 0);
        chk("t4_preempt_tone_en", bus.tone_en, 1);
        step();
        chk("t4_preempt_period", bus.tone_period, 12500);
`else
        chk("t4_wait_id", bus.active_id, 1);
        chk("t4_wait_period", bus.tone_period, 9000);
        tick_pulse();
        step();
        chk("t4_sfx1_done", bus.sfx_done, 1);
        chk("t4_sfx1_done_id", bus.active_id, 1);
        step(2);
        chk("t4_sfx0_load_id", bus.active_id, 0);
        step();
        chk("t4_sfx0_period", bus.tone_period, 12500);
`endif
        play_sfx0_rest("t4");
        step(10);

        // Re-request of the playing effect replays it right after completion.
        push_sfx0();
        push_sfx0();
        done_mark = done_cnt;
        req(4'b0001);
        step(2);
        step(5);
        req(4'b0001);
        play_sfx0_rest("t5a");
        step();
        chk("t5_reload_busy", bus.busy, 1);
        chk("t5_reload_id", bus.active_id, 0);
        step();
        chk("t5_replay_period", bus.tone_period, 12500);
        play_sfx0_rest("t5b");
        chk("t5_done_count", done_cnt - done_mark, 2);
        step(10);

        // Empty effect: straight LOAD -> DONE, tone never enabled.
        push_done(2);
        req(4'b0100);
        step();
        chk("e2_load_tone_en", bus.tone_en, 0);
        step();
        chk("e2_done", bus.sfx_done, 1);
        chk("e2_done_tone_en", bus.tone_en, 0);
        chk("e2_done_id", bus.active_id, 2);
        step(10);

        // Full-length effect: ends at NOTES_MAX without an end marker.
        push_note(1000, 16);
        push_note(2000, 32);
        push_note(3000, 64);
        push_note(4000, 128);
        push_done(3);
        req(4'b1000);
        step(2);
        chk("e3_n0_period", bus.tone_period, 1000);
        for (int n = 1; n < 4; n++) begin
            tick_pulse();
            step();
            chk("e3_note_period", bus.tone_period, 1000 * (n + 1));
        end
        tick_pulse();
        chk("e3_wrap_done", bus.sfx_done, 1);
        step();
        chk("e3_idle_busy", bus.busy, 0);
        step(10);

        // Asynchronous reset mid-PLAY with another request pending.
        push_note(12500, 128);
        req(4'b0001);
        step(12);
        req(4'b0010);
        step(5);
        #2;
        rst = 1'b1;
        #1;
        chk("t1_rst_tone_en", bus.tone_en, 0);
        chk("t1_rst_busy", bus.busy, 0);
        chk("t1_rst_done", bus.sfx_done, 0);
        step(2);
        rst = 1'b0;
        tick_pulse();
        tick_pulse();
        tick_pulse();
        chk("t1_post_busy", bus.busy, 0);
        chk("t1_post_tone_en", bus.tone_en, 0);
        step(2);

        chk("sb_drain", exp_q.size(), 0);
        chk("done_total", done_cnt, EXP_DONE);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
